// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: sample/control inputs and match outputs.
// The master modport drives stimulus; the slave modport is the detector side.
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             x;
    logic             load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap;
    logic             clr_cnt;
    logic             z;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, x, load, pat_in, overlap, clr_cnt,
        input  z, match_cnt
    );

    modport slave (
        input  en, x, load, pat_in, overlap, clr_cnt,
        output z, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with Mealy match flag.
// A loadable PAT_W-bit pattern is compared against the last PAT_W sampled
// bits; overlap selects whether a match suffix may seed the next match.
// Optional macro SEQ_DETECT_CNT_EN compiles in a saturating match counter
// with synchronous clear; without it match_cnt is tied to zero.
// Interface parameters PAT_W/CNT_W must equal the module parameters.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter int unsigned      CNT_W   = 8,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(4'b1011)
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_param_if.slave  bus
);

    localparam int unsigned HIST_W = PAT_W - 1;
    localparam int unsigned FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_q,  pat_d;
    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              z_c;

    // Mealy match: full history window plus current bit equals the pattern.
    always_comb begin
        z_c = bus.en & ~bus.load & (fill_q == FILL_MAX) & ({hist_q, bus.x} == pat_q);
    end

    assign bus.z = z_c;

    // Next-state for pattern, history and fill; load has priority over sampling.
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        if (bus.load) begin
            pat_d  = bus.pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = HIST_W'({hist_q, bus.x});
            if (z_c && !bus.overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // Detector state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= RST_PAT;
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match count; clear beats a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (z_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Match counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (PAT_W=4, CNT_W=2).
// Expected counts follow SEQ_DETECT_CNT_EN: zero when the counter is absent.
module tb_seq_detect_param;

    localparam int unsigned PAT_W = 4;
    localparam int unsigned CNT_W = 2;
`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   exp_cnt;

    seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, check z and count before the edge, update model.
    task automatic step(input logic e, input logic xb, input logic ld,
                        input logic [PAT_W-1:0] p, input logic clr,
                        input logic exp_z, input string tag);
        bus.en      = e;
        bus.x       = xb;
        bus.load    = ld;
        bus.pat_in  = p;
        bus.clr_cnt = clr;
        @(negedge clk);
        chk({tag, "_z"}, 32'(bus.z), 32'(exp_z));
        chk({tag, "_cnt"}, 32'(bus.match_cnt), CNT_ON ? 32'(exp_cnt) : 32'd0);
        if (clr) exp_cnt = 0;
        else if (exp_z && exp_cnt != 3) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Enabled bit stream, first bit at index n-1.
    task automatic run(input string tag, input int n, input logic [15:0] xs, input logic [15:0] zs);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, xs[i], 1'b0, '0, 1'b0, zs[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic load_pat(input logic [PAT_W-1:0] p, input string tag);
        step(1'b1, 1'b1, 1'b1, p, 1'b0, 1'b0, tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_cnt = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.x = 1'b0; bus.load = 1'b0;
        bus.pat_in = '0; bus.overlap = 1'b0; bus.clr_cnt = 1'b0;

        // Reset state
        #1;
        bus.en = 1'b1; bus.x = 1'b1;
        #1;
        chk("rst_z", 32'(bus.z), 32'd0);
        chk("rst_cnt", 32'(bus.match_cnt), 32'd0);
        bus.en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Overlapping detection of reset pattern 1011
        bus.overlap = 1'b1;
        run("ovl", 7, 16'b1011011, 16'b0001001);
        load_pat(4'b1011, "ld1");

        // Non-overlapping: needs fresh bits after a match; count saturates at 3
        bus.overlap = 1'b0;
        run("novl", 8, 16'b10111011, 16'b00010001);
        step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0, "clr1");
        load_pat(4'b1011, "ld2");
        run("novl2", 7, 16'b1011011, 16'b0001000);

        // Load mid-stream discards history; new pattern 1101
        run("pre", 3, 16'b110, 16'b000);
        load_pat(4'b1101, "ld3");
        run("post", 4, 16'b1101, 16'b0001);

        // en gating with garbage on disabled cycles
        load_pat(4'b1011, "ld4");
        bus.overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, "en1");
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "en2");
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "en3");
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, "en4");
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, "en5");
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "en6");
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, "en7");

        // Saturation over overlapping matches, then clear coincident with 5th match
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, "clr2");
        load_pat(4'b1011, "ld5");
        run("sat", 13, 16'b1011011011011, 16'b0001001001001);
        run("sat5", 2, 16'b01, 16'b00);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1, "satclr");
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, "after_clr");

        // Reset mid-pattern restores RST_PAT and restarts fill
        load_pat(4'b1101, "ld6");
        run("mid", 3, 16'b101, 16'b000);
        rst_n = 1'b0;
        bus.en = 1'b1; bus.x = 1'b1;
        #1;
        exp_cnt = 0;
        chk("midrst_z", 32'(bus.z), 32'd0);
        chk("midrst_cnt", 32'(bus.match_cnt), 32'd0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("rel", 4, 16'b1011, 16'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter CNT_W, default 8: width of the match counter, legal range 1..16.
REQ-003 Parameter RST_PAT, default 4'b1011 zero-extended to PAT_W: pattern register value after reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 en  input  1  sample strobe; x is consumed only on cycles with en=1.
REQ-007 x  input  1  serial data bit.
REQ-008 load  input  1  capture pat_in into the pattern register.
REQ-009 pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
REQ-010 overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-011 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-012 z  output  1  Mealy match flag, combinational from the current state and inputs.
REQ-013 match_cnt  output  CNT_W  saturating count of asserted z cycles.

Function
REQ-014 State: pattern register pat[PAT_W-1:0]; history shift register hist[PAT_W-2:0], newest bit at LSB; fill counter fill in 0..PAT_W-1.
REQ-015 z = en & ~load & (fill == PAT_W-1) & ({hist, x} == pat), all evaluated in the same cycle. Zero latency; no registered delay.
REQ-016 Any cycle with en=1 and load=0: hist shifts left with x entering at the LSB; fill increments, saturating at PAT_W-1.
REQ-017 Cycle with z=1 and overlap=1: hist shifts normally; fill stays at PAT_W-1, so the match suffix may seed the next match.
REQ-018 Cycle with z=1 and overlap=0: fill is cleared to 0; the next match needs PAT_W fresh bits.
REQ-019 Cycle with en=0: hist, fill, and match_cnt (except clr_cnt) hold; z=0.
REQ-020 load=1: pat <= pat_in; hist <= 0; fill <= 0; any en/x sample that cycle is discarded; z=0.
REQ-021 overlap is sampled on each match cycle only; changing it mid-stream affects the next match and does not alter history.
REQ-022 match_cnt increments by 1 on each z=1 cycle and saturates at 2^CNT_W-1 with no wrap.
REQ-023 If clr_cnt and z are both 1 in the same cycle, clr_cnt wins and match_cnt becomes 0.

Reset
REQ-024 rst_n=0 asynchronously sets pat=RST_PAT, hist=0, fill=0, match_cnt=0; z=0 while reset is asserted.
REQ-025 Reset asserted mid-pattern discards the partial match; after release, detection restarts with fill=0.
REQ-026 Reset deassertion is synchronised externally; the block needs no internal reset synchroniser.

Configuration
REQ-027 Macro SEQ_DETECT_CNT_EN defined: the match counter and the clr_cnt logic are compiled in, per REQ-022/REQ-023.
REQ-028 Macro SEQ_DETECT_CNT_EN undefined: no counter flops exist; match_cnt is tied to 0; clr_cnt is ignored; z behaviour is unchanged.

Verification
REQ-029 Reset, PAT_W=4, overlap=1, en=1, x stream 1,0,1,1,0,1,1 -> z=1 on the 4th and 7th bits only; match_cnt=2.
REQ-030 Same setup with overlap=0, x stream 1,0,1,1,1,0,1,1 -> z=1 on the 4th and 8th bits only; stream 1,0,1,1,0,1,1 -> z=1 on the 4th bit only.
REQ-031 load with pat_in=4'b1101 mid-stream, then x stream 1,1,0,1 -> z=1 on the 4th bit; bits sent before the load never contribute to a match.
REQ-032 en toggled 1,0,1,0,... with x=1,0,1,1 on the enabled cycles and x garbage on disabled cycles -> z=1 only on the enabled cycle carrying the final 1.
REQ-033 CNT_W=2 with 5 overlapping matches -> match_cnt saturates at 3; clr_cnt coincident with a match -> match_cnt=0.
REQ-034 rst_n pulsed low after bits 1,0,1 and then x=1 -> z=0, fill=1; compile without SEQ_DETECT_CNT_EN -> match_cnt stays 0 throughout.
